// File: rtl/cpu_defs.sv
// Shared ROB definitions: default geometry,
// index type and the CDB writeback bundle.
package cpu_defs;

  localparam int ROB_WIDTH     = 2;
  localparam int ROB_DEPTH     = 16;
  localparam int ROB_DATA_W    = 64;
  localparam int ROB_RES_W     = 32;
  localparam int ROB_CDB_PORTS = 2;
  localparam int ROB_IW        = $clog2(ROB_DEPTH);

  typedef logic [ROB_IW-1:0] rob_index_t;

  typedef struct packed {
    logic                  valid;
    rob_index_t            reorder;
    logic [ROB_RES_W-1:0]  result;
  } cdb_port_t;

endpackage

// File: rtl/rob_head_window.sv
// Commit-side view of the ROB: head+i indices,
// per-lane head status muxing and pop legality.
module rob_head_window
  import cpu_defs::*;
#(
  parameter int  WIDTH  = ROB_WIDTH,
  parameter int  DEPTH  = ROB_DEPTH,
  parameter int  DATA_W = ROB_DATA_W,
  parameter int  RES_W  = ROB_RES_W,
  localparam int IW     = $clog2(DEPTH),
  localparam int CW     = $clog2(WIDTH+1)
) (
  input  logic [IW-1:0]                  head_i,
  input  logic [CW-1:0]                  pop_cnt_i,
  input  logic [DEPTH-1:0]               valid_i,
  input  logic [DEPTH-1:0]               done_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]   data_i,
  input  logic [DEPTH-1:0][RES_W-1:0]    res_i,
  output logic [WIDTH*IW-1:0]            commit_idx_o,
  output logic [WIDTH-1:0]               head_valid_o,
  output logic [WIDTH-1:0]               head_done_o,
  output logic [WIDTH*DATA_W-1:0]        head_data_o,
  output logic [WIDTH*RES_W-1:0]         head_result_o,
  output logic                           pop_ok_o
);

  logic [IW-1:0] hidx [WIDTH];

  // head+i wraps naturally in IW bits
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      hidx[i] = head_i + IW'(i);
    end
  end

  // per-lane head window mux
  always_comb begin
    commit_idx_o  = '0;
    head_valid_o  = '0;
    head_done_o   = '0;
    head_data_o   = '0;
    head_result_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      commit_idx_o[i*IW +: IW] = hidx[i];
      head_valid_o[i] = valid_i[hidx[i]];
      head_done_o[i]  = valid_i[hidx[i]]
                      & done_i[hidx[i]];
      head_data_o[i*DATA_W +: DATA_W] =
        data_i[hidx[i]];
      head_result_o[i*RES_W +: RES_W] =
        res_i[hidx[i]];
    end
  end

  // pop needs every retired lane done, in order
  always_comb begin
    pop_ok_o = (pop_cnt_i <= CW'(WIDTH));
    for (int i = 0; i < WIDTH; i++) begin
      if ((CW'(i) < pop_cnt_i) && !head_done_o[i])
        pop_ok_o = 1'b0;
    end
  end

endmodule

// File: rtl/rob_multi.sv
// Multi-lane reorder buffer: circular storage,
// head/tail pointers, occupancy and CDB writeback.
module rob_multi
  import cpu_defs::*;
#(
  parameter int  WIDTH     = ROB_WIDTH,
  parameter int  DEPTH     = ROB_DEPTH,
  parameter int  DATA_W    = ROB_DATA_W,
  parameter int  RES_W     = ROB_RES_W,
  parameter int  CDB_PORTS = ROB_CDB_PORTS,
  localparam int IW        = $clog2(DEPTH),
  localparam int CW        = $clog2(WIDTH+1),
  localparam int NW        = $clog2(DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [CW-1:0]               push_cnt,
  input  logic [WIDTH*DATA_W-1:0]     push_data,
  input  logic [CW-1:0]               pop_cnt,
  output logic [WIDTH*IW-1:0]         reorder,
  output logic [WIDTH*IW-1:0]         reorder_commit,
  output logic [WIDTH-1:0]            head_valid,
  output logic [WIDTH-1:0]            head_done,
  output logic [WIDTH*DATA_W-1:0]     head_data,
  output logic [WIDTH*RES_W-1:0]      head_result,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*IW-1:0]     cdb_reorder,
  input  logic [CDB_PORTS*RES_W-1:0]  cdb_result,
  output logic [NW-1:0]               count,
  output logic [NW-1:0]               free_cnt,
  output logic                        full,
  output logic                        empty,
  output logic                        err
);

  logic [IW-1:0]               head_q, head_d;
  logic [IW-1:0]               tail_q, tail_d;
  logic [NW-1:0]               count_q, count_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0]            done_q, done_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0][RES_W-1:0]  res_q, res_d;
  logic                        err_q, err_d;
  logic                        push_ok, pop_ok;
  logic [CW-1:0]               push_n, pop_n;
  logic [IW-1:0]               tidx [WIDTH];
  logic [IW-1:0]               hidx [WIDTH];
  logic [IW-1:0]               cidx;

  rob_head_window #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_head (
    .head_i        (head_q),
    .pop_cnt_i     (pop_cnt),
    .valid_i       (valid_q),
    .done_i        (done_q),
    .data_i        (data_q),
    .res_i         (res_q),
    .commit_idx_o  (reorder_commit),
    .head_valid_o  (head_valid),
    .head_done_o   (head_done),
    .head_data_o   (head_data),
    .head_result_o (head_result),
    .pop_ok_o      (pop_ok)
  );

  assign free_cnt = NW'(DEPTH) - count_q;
  assign count    = count_q;
  assign full     = (count_q == NW'(DEPTH));
  assign empty    = (count_q == '0);
  assign err      = err_q;

  // space is judged before this cycle's pop
  assign push_ok = (push_cnt <= CW'(WIDTH))
                 && (NW'(push_cnt) <= free_cnt);
  assign push_n  = push_ok ? push_cnt : '0;
  assign pop_n   = pop_ok  ? pop_cnt  : '0;

  // tail+i and head+i lane indices
  always_comb begin
    reorder = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tidx[i] = tail_q + IW'(i);
      hidx[i] = reorder_commit[i*IW +: IW];
      reorder[i*IW +: IW] = tidx[i];
    end
  end

  // entry next state: CDB, then pop, then push
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    data_d  = data_q;
    res_d   = res_q;
    cidx    = '0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      cidx = cdb_reorder[p*IW +: IW];
      if (cdb_valid[p] && valid_q[cidx]) begin
        done_d[cidx] = 1'b1;
        res_d[cidx]  = cdb_result[p*RES_W +: RES_W];
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) < pop_n) begin
        valid_d[hidx[i]] = 1'b0;
        done_d[hidx[i]]  = 1'b0;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) < push_n) begin
        valid_d[tidx[i]] = 1'b1;
        done_d[tidx[i]]  = 1'b0;
        data_d[tidx[i]]  =
          push_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // pointer, occupancy and error next state
  always_comb begin
    head_d  = head_q + IW'(pop_n);
    tail_d  = tail_q + IW'(push_n);
    count_d = count_q + NW'(push_n) - NW'(pop_n);
    err_d   = !push_ok || !pop_ok;
  end

  // control state; reset and flush clear it all
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // payload storage, qualified by valid bits
  always_ff @(posedge clk) begin
    data_q <= data_d;
    res_q  <= res_d;
  end

endmodule

// File: tb/tb_rob_multi.sv
// Scoreboard bench for rob_multi: directed
// stimulus queues expectations, monitor compares.
module tb_rob_multi;

  localparam int W  = 2;
  localparam int D  = 16;
  localparam int DW = 64;
  localparam int RW = 32;
  localparam int CP = 2;

  localparam int F_CNT   = 0;
  localparam int F_EMPTY = 1;
  localparam int F_FULL  = 2;
  localparam int F_FREE  = 3;
  localparam int F_ERR   = 4;
  localparam int F_REO   = 5;
  localparam int F_COM   = 6;
  localparam int F_HV    = 7;
  localparam int F_HD    = 8;
  localparam int F_HR0   = 9;
  localparam int F_HR1   = 10;
  localparam int F_DAT0  = 11;
  localparam int F_DAT1  = 12;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [1:0]      push_cnt;
  logic [W*DW-1:0] push_data;
  logic [1:0]      pop_cnt;
  logic [W*4-1:0]  reorder;
  logic [W*4-1:0]  reorder_commit;
  logic [W-1:0]    head_valid;
  logic [W-1:0]    head_done;
  logic [W*DW-1:0] head_data;
  logic [W*RW-1:0] head_result;
  logic [CP-1:0]   cdb_valid;
  logic [CP*4-1:0] cdb_reorder;
  logic [CP*RW-1:0] cdb_result;
  logic [4:0]      count;
  logic [4:0]      free_cnt;
  logic            full;
  logic            empty;
  logic            err;

  rob_multi dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .push_cnt       (push_cnt),
    .push_data      (push_data),
    .pop_cnt        (pop_cnt),
    .reorder        (reorder),
    .reorder_commit (reorder_commit),
    .head_valid     (head_valid),
    .head_done      (head_done),
    .head_data      (head_data),
    .head_result    (head_result),
    .cdb_valid      (cdb_valid),
    .cdb_reorder    (cdb_reorder),
    .cdb_result     (cdb_result),
    .count          (count),
    .free_cnt       (free_cnt),
    .full           (full),
    .empty          (empty),
    .err            (err)
  );

  typedef struct {
    int          cyc;
    string       name;
    int          f;
    logic [63:0] v;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] get(int f);
    case (f)
      F_CNT:   return 64'(count);
      F_EMPTY: return 64'(empty);
      F_FULL:  return 64'(full);
      F_FREE:  return 64'(free_cnt);
      F_ERR:   return 64'(err);
      F_REO:   return 64'(reorder);
      F_COM:   return 64'(reorder_commit);
      F_HV:    return 64'(head_valid);
      F_HD:    return 64'(head_done);
      F_HR0:   return 64'(head_result[31:0]);
      F_HR1:   return 64'(head_result[63:32]);
      F_DAT0:  return head_data[63:0];
      F_DAT1:  return head_data[127:64];
      default: return 64'hdead_beef_dead_beef;
    endcase
  endfunction

  function automatic logic [63:0] pr(int a, int b);
    return 64'({4'(b), 4'(a)});
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      nvec++;
      if (get(me.f) !== me.v) begin
        nerr++;
        $display("FAIL %s: got %0h expected %0h",
                 me.name, get(me.f), me.v);
      end
    end
  end

  task automatic E(string n, int f,
                   logic [63:0] v);
    q.push_back('{cyc + 1, n, f, v});
  endtask

  task automatic EN(string n, int f,
                    logic [63:0] v);
    q.push_back('{cyc, n, f, v});
  endtask

  task automatic idle();
    rst         = 1'b1;
    flush       = 1'b0;
    push_cnt    = '0;
    pop_cnt     = '0;
    cdb_valid   = '0;
    cdb_reorder = '0;
    cdb_result  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic cdb(logic v0, int i0, int r0,
                     logic v1, int i1, int r1);
    cdb_valid   = {v1, v0};
    cdb_reorder = {4'(i1), 4'(i0)};
    cdb_result  = {32'(r1), 32'(r0)};
  endtask

  task automatic do_reset();
    rst = 1'b0;
    E("rst_count", F_CNT, 0);
    tick();
  endtask

  task automatic fill();
    for (int k = 0; k < 8; k++) begin
      EN("fill_reorder", F_REO,
         pr(2*k, 2*k+1));
      push_cnt  = 2;
      push_data = {64'(256 + 2*k + 1),
                   64'(256 + 2*k)};
      E("fill_count", F_CNT, 64'(2*k + 2));
      tick();
    end
  endtask

  task automatic flush_checks(string t);
    E({t, "_empty"}, F_EMPTY, 1);
    E({t, "_count"}, F_CNT, 0);
    E({t, "_free"}, F_FREE, 16);
    E({t, "_reo"}, F_REO, pr(0, 1));
    E({t, "_com"}, F_COM, pr(0, 1));
    E({t, "_hv"}, F_HV, 0);
    E({t, "_hd"}, F_HD, 0);
    E({t, "_err"}, F_ERR, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    push_data = '0;
    rst = 1'b0;
    E("r_count", F_CNT, 0);
    E("r_empty", F_EMPTY, 1);
    E("r_full", F_FULL, 0);
    E("r_free", F_FREE, 16);
    E("r_hv", F_HV, 0);
    E("r_hd", F_HD, 0);
    E("r_reo", F_REO, pr(0, 1));
    E("r_com", F_COM, pr(0, 1));
    E("r_err", F_ERR, 0);
    tick();
    nvec++;
    if (empty !== 1'b1) begin
      nerr++;
      $display("FAIL d_rst_empty: got %0h expected 1",
               empty);
    end
    nvec++;
    if (free_cnt !== 5'd16) begin
      nerr++;
      $display("FAIL d_rst_free: got %0h expected 10",
               free_cnt);
    end

    fill();
    nvec++;
    if (full !== 1'b1) begin
      nerr++;
      $display("FAIL d_fill_full: got %0h expected 1",
               full);
    end
    nvec++;
    if (count !== 5'd16) begin
      nerr++;
      $display("FAIL d_fill_cnt: got %0h expected 10",
               count);
    end
    EN("t1_full", F_FULL, 1);
    EN("t1_free", F_FREE, 0);
    EN("t1_hv", F_HV, 3);
    EN("t1_hd", F_HD, 0);
    EN("t1_reo", F_REO, pr(0, 1));
    EN("t1_dat0", F_DAT0, 256);
    EN("t1_dat1", F_DAT1, 257);
    push_cnt = 1;
    E("t1_ovf_err", F_ERR, 1);
    E("t1_ovf_cnt", F_CNT, 16);
    tick();
    nvec++;
    if (err !== 1'b1) begin
      nerr++;
      $display("FAIL d_ovf_err: got %0h expected 1",
               err);
    end
    E("t1_err_clr", F_ERR, 0);
    tick();

    cdb(1, 1, 'h55, 0, 0, 0);
    E("t2_hd_lane1", F_HD, 2);
    E("t2_err0", F_ERR, 0);
    tick();
    pop_cnt = 1;
    E("t2_badpop_err", F_ERR, 1);
    E("t2_badpop_cnt", F_CNT, 16);
    E("t2_badpop_hd", F_HD, 2);
    tick();
    cdb(1, 0, 'hAA, 0, 0, 0);
    E("t2_hd_both", F_HD, 3);
    E("t2_hr0", F_HR0, 'hAA);
    E("t2_hr1", F_HR1, 'h55);
    tick();
    pop_cnt = 2;
    E("t2_pop_cnt", F_CNT, 14);
    E("t2_pop_com", F_COM, pr(2, 3));
    E("t2_pop_hd", F_HD, 0);
    E("t2_pop_full", F_FULL, 0);
    E("t2_pop_free", F_FREE, 2);
    tick();

    do_reset();
    fill();
    for (int j = 0; j < 8; j++) begin
      cdb(1, 2*j, 'h1000 + 2*j,
          1, 2*j+1, 'h1000 + 2*j + 1);
      tick();
    end
    for (int n = 0; n < 7; n++) begin
      pop_cnt = 2;
      E("t3_pop_cnt", F_CNT, 64'(14 - 2*n));
      tick();
    end
    pop_cnt = 1;
    E("t3_last_cnt", F_CNT, 1);
    E("t3_last_com", F_COM, pr(15, 0));
    E("t3_last_hv", F_HV, 1);
    E("t3_last_hd", F_HD, 1);
    tick();
    EN("t3_wrap_reo", F_REO, pr(0, 1));
    push_cnt  = 2;
    push_data = {64'hB1B1, 64'hA0A0};
    E("t3_wrap_cnt", F_CNT, 3);
    E("t3_wrap_com", F_COM, pr(15, 0));
    E("t3_wrap_hv", F_HV, 3);
    E("t3_wrap_hd", F_HD, 1);
    E("t3_wrap_dat1", F_DAT1, 'hA0A0);
    tick();
    cdb(1, 0, 'h77, 0, 0, 0);
    E("t3_wrap_cdb_hd", F_HD, 3);
    E("t3_wrap_cdb_hr1", F_HR1, 'h77);
    tick();

    do_reset();
    fill();
    cdb(1, 0, 'h10, 1, 1, 'h20);
    tick();
    push_cnt = 1;
    pop_cnt  = 2;
    E("t4_err", F_ERR, 1);
    E("t4_cnt", F_CNT, 14);
    E("t4_com", F_COM, pr(2, 3));
    E("t4_full", F_FULL, 0);
    tick();
    EN("t4_reo", F_REO, pr(0, 1));
    push_cnt  = 2;
    push_data = {64'hC1, 64'hC0};
    E("t4_refill_cnt", F_CNT, 16);
    E("t4_refill_full", F_FULL, 1);
    E("t4_refill_err", F_ERR, 0);
    tick();

    cdb(1, 2, 'h2, 1, 3, 'h3);
    tick();
    pop_cnt = 2;
    E("t5_pop_cnt", F_CNT, 14);
    E("t5_pop_com", F_COM, pr(4, 5));
    tick();
    cdb(1, 5, 'h11, 1, 5, 'h22);
    E("t5_same_hd", F_HD, 2);
    E("t5_same_hr1", F_HR1, 'h22);
    tick();
    cdb(1, 2, 'h99, 0, 0, 0);
    E("t5_freed_cnt", F_CNT, 14);
    E("t5_freed_hd", F_HD, 2);
    E("t5_freed_hv", F_HV, 3);
    E("t5_freed_hr1", F_HR1, 'h22);
    E("t5_freed_err", F_ERR, 0);
    tick();

    flush    = 1'b1;
    push_cnt = 2;
    pop_cnt  = 1;
    cdb(1, 4, 'h44, 0, 0, 0);
    flush_checks("t6_flush");
    tick();
    for (int k = 0; k < 3; k++) begin
      push_cnt  = 2;
      push_data = {64'(k+1), 64'(k)};
      tick();
    end
    rst      = 1'b0;
    push_cnt = 2;
    pop_cnt  = 1;
    cdb(1, 0, 'h44, 0, 0, 0);
    flush_checks("t6_rst");
    tick();
    EN("t6_after_reo", F_REO, pr(0, 1));
    push_cnt  = 1;
    push_data = {64'h0, 64'hE0};
    E("t6_after_cnt", F_CNT, 1);
    E("t6_after_hv", F_HV, 1);
    E("t6_after_dat0", F_DAT0, 'hE0);
    tick();

    tick();
    tick();
    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      me = q.pop_front();
      nvec++;
      nerr++;
      $display("FAIL leftover %s: got unchecked expected checked",
               me.name);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
